mux4_word_serializer: RTL and testbench
=======================================

// Module: mux4_word_serializer
// PURPOSE
//   Upstream stage of the 32-bit yMux4to1 word selector. Collects a frame of 1-4 words over
//   a valid/ready input, holds them on the mux data inputs a0..a3, then steps the 2-bit mux
//   select 0,1,2,.. once per accepted output beat. The external mux output z is the word stream.
//   Converts a burst of words into a selectable bank plus sequenced select and valid/last flags.
// PARAMETERS
//   SIZE   32   data width of in_data and a0..a3
// PORTS
//   clk        in   1     clock, all state updates on rising edge
//   reset      in   1     synchronous, active-high reset
//   in_valid   in   1     in_data carries a word
//   in_last    in   1     qualifies in_data as final word of a short frame
//   in_data    in   SIZE  word to load
//   in_ready   out  1     block accepts a word this cycle
//   a0..a3     out  SIZE  slot contents, wired to mux data inputs a0..a3
//   sel        out  2     mux select, wired to mux c
//   out_valid  out  1     word on mux z (slot sel) is valid
//   out_ready  in   1     consumer accepts the z word
//   out_last   out  1     current out beat is final word of frame
//   frame_len  out  3     number of words in the held frame (1..4, 0 when loading)
// BEHAVIOUR
//   Clock/reset: one clock, clk; reset synchronous active-high, sampled on rising clk.
//   Reset: state=LOAD, a0..a3=0, sel=0, wr_ptr=0, frame_len=0, out_valid=0, out_last=0.
//     in_ready=1 on the first cycle after reset deassertion.
//   States: LOAD, DRAIN (2-state FSM, registered).
//   LOAD: in_ready=1, out_valid=0, sel=0.
//     - Accept when in_valid&&in_ready: slot[wr_ptr]<=in_data, wr_ptr<=wr_ptr+1.
//     - Go DRAIN when accepted word is 4th (wr_ptr==3) or in_last=1; frame_len<=wr_ptr+1.
//     - in_last on 4th word: same as plain 4th word (frame_len=4).
//     - Slots not written in a short frame hold 0 (cleared on LOAD entry).
//   DRAIN: in_ready=0, out_valid=1, sel=rd_ptr.
//     - out_last = (rd_ptr==frame_len-1), combinational from registered state.
//     - Beat completes when out_valid&&out_ready: rd_ptr<=rd_ptr+1.
//     - Last beat: next cycle state=LOAD, all slots=0, wr_ptr=rd_ptr=0, frame_len=0.
//     - out_ready low: sel, a0..a3, out_last held stable (no advance).
//   Timing: word written at edge N is visible on aX at N+1. First out beat is the cycle
//     after the frame-completing accept. No overlap of LOAD and DRAIN: min 4+4 cycles per
//     4-word frame; in_valid during DRAIN is ignored (in_ready=0, no data lost upstream).
//   Widths: wr_ptr, rd_ptr 2 bits; wrap impossible by construction (max index 3).
//   Reset mid-frame (either state): partial frame discarded, outputs return to reset values
//     next cycle; no out beat is produced for it.
//   a0..a3 change only in LOAD (write/clear) or on reset; stable for the whole DRAIN.
// TESTING
//   1 reset, then words 11,22,33,44 with in_valid=1, out_ready=1 -> sel 0,1,2,3 over 4 beats,
//     z=11,22,33,44, out_last only on z=44, in_ready=1 again on next cycle.
//   2 short frame: A5A5A5A5 then 5A5A5A5A with in_last=1 -> frame_len=2, a2=a3=0,
//     two beats, out_last on 5A5A5A5A, back to LOAD.
//   3 backpressure: full frame, out_ready=0 for 3 cycles mid-drain at sel=1 -> sel,
//     a0..a3, out_valid held; resumes at sel=1 then 2,3, no beat duplicated or lost.
//   4 in_valid held high during DRAIN with word DEADBEEF -> not captured; in_ready=0
//     throughout; next frame's slot 0 = first word offered after return to LOAD.
//   5 reset asserted after 2 words loaded, and again at sel=2 in DRAIN -> next cycle
//     a0..a3=0, sel=0, out_valid=0, in_ready=1, frame_len=0.
//   6 randomized 200 frames (length 1-4, random in_valid/out_ready gaps) vs scoreboard:
//     z stream == input stream in order, out_last count == frame count.

Source files
------------

// File: rtl/mux4_word_serializer.sv
// Word serializer feeding a 4:1 word mux: loads a 1-4 word frame into slots a0..a3,
// then steps the mux select once per accepted output beat.
module mux4_word_serializer #(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_last,
  input  logic [SIZE-1:0] in_data,
  output logic            in_ready,
  output logic [SIZE-1:0] a0,
  output logic [SIZE-1:0] a1,
  output logic [SIZE-1:0] a2,
  output logic [SIZE-1:0] a3,
  output logic [1:0]      sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [2:0]      frame_len
);

  localparam int unsigned PTR_W = 2;
  localparam int unsigned LEN_W = 3;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              accept;
  logic              frame_done;
  logic              beat;
  logic              drain_done;

  // Final beat is decoded from registered pointer and length only.
  assign out_last = (state == DRAIN) && (LEN_W'(rd_ptr) == (frame_len - LEN_W'(1)));
  assign sel      = rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    frame_done = 1'b0;
    beat       = 1'b0;
    drain_done = 1'b0;
    case (state)
      LOAD: begin
        in_ready   = 1'b1;
        accept     = in_valid;
        frame_done = in_valid && ((wr_ptr == PTR_W'(3)) || in_last);
        if (frame_done) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        out_valid  = 1'b1;
        beat       = out_ready;
        drain_done = out_ready && out_last;
        if (drain_done) begin
          state_nxt = LOAD;
        end
      end
    endcase
  end

  // Slot bank, pointers and frame length; slots are cleared on the way back to LOAD
  // so unwritten slots of a short frame read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      a0        <= '0;
      a1        <= '0;
      a2        <= '0;
      a3        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_len <= '0;
    end else if (accept) begin
      case (wr_ptr)
        2'd0:    a0 <= in_data;
        2'd1:    a1 <= in_data;
        2'd2:    a2 <= in_data;
        default: a3 <= in_data;
      endcase
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (frame_done) begin
        frame_len <= LEN_W'(wr_ptr) + LEN_W'(1);
      end
    end else if (beat) begin
      if (drain_done) begin
        a0        <= '0;
        a1        <= '0;
        a2        <= '0;
        a3        <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        frame_len <= '0;
      end else begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux4_word_serializer.sv
// Directed and randomized checks of the frame serializer, with the downstream 4:1 mux modelled here.
module tb_mux4_word_serializer;

  localparam int unsigned SIZE = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_last;
  logic [SIZE-1:0] in_data;
  logic            in_ready;
  logic [SIZE-1:0] a0, a1, a2, a3;
  logic [1:0]      sel;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [2:0]      frame_len;
  logic [SIZE-1:0] z;

  int total = 0;
  int bad   = 0;

  mux4_word_serializer #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  // External 32-bit 4:1 mux.
  always_comb begin
    case (sel)
      2'd0:    z = a0;
      2'd1:    z = a1;
      2'd2:    z = a2;
      default: z = a3;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    total++;
    if ({in_ready, out_valid, out_last, sel, frame_len} !== {1'b1, 1'b0, 1'b0, 2'd0, 3'd0}) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy/vld/last/sel/len=%b, want 1_0_0_00_000",
               {in_ready, out_valid, out_last, sel, frame_len});
    end
    total++;
    if ({a0, a1, a2, a3} !== 128'd0) begin
      bad++;
      $display("FAIL reset_slots: got %h %h %h %h, want all 0", a0, a1, a2, a3);
    end
  endtask

  task automatic test_full_frame();
    logic [31:0] w [4] = '{32'd11, 32'd22, 32'd33, 32'd44};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i]; in_last = 1'b0;
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL full_load_ready[%0d]: got %b want 1", i, in_ready);
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({out_valid, out_last, sel, frame_len, z} !== {1'b1, (i == 3), 2'(i), 3'd4, w[i]}) begin
        bad++;
        $display("FAIL full_beat[%0d]: got vld=%b last=%b sel=%0d len=%0d z=%0d, want 1 %0d %0d 4 %0d",
                 i, out_valid, out_last, sel, frame_len, z, (i == 3), i, w[i]);
      end
      step();
    end
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid, frame_len, a0} !== {1'b1, 1'b0, 3'd0, 32'd0}) begin
      bad++;
      $display("FAIL full_return: got rdy=%b vld=%b len=%0d a0=%h, want 1 0 0 0",
               in_ready, out_valid, frame_len, a0);
    end
  endtask

  task automatic test_short_frame();
    in_valid = 1'b1; in_data = 32'hA5A5A5A5; in_last = 1'b0;
    step();
    in_data = 32'h5A5A5A5A; in_last = 1'b1;
    step();
    idle();
    total++;
    if ({frame_len, a0, a1, a2, a3} !== {3'd2, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL short_bank: got len=%0d %h %h %h %h, want 2 a5a5a5a5 5a5a5a5a 0 0",
               frame_len, a0, a1, a2, a3);
    end
    out_ready = 1'b1;
    total++;
    if ({out_valid, out_last, sel, z} !== {1'b1, 1'b0, 2'd0, 32'hA5A5A5A5}) begin
      bad++;
      $display("FAIL short_beat0: got vld=%b last=%b sel=%0d z=%h", out_valid, out_last, sel, z);
    end
    step();
    total++;
    if ({out_valid, out_last, sel, z} !== {1'b1, 1'b1, 2'd1, 32'h5A5A5A5A}) begin
      bad++;
      $display("FAIL short_beat1: got vld=%b last=%b sel=%0d z=%h", out_valid, out_last, sel, z);
    end
    step();
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid, frame_len, a1} !== {1'b1, 1'b0, 3'd0, 32'd0}) begin
      bad++;
      $display("FAIL short_return: got rdy=%b vld=%b len=%0d a1=%h", in_ready, out_valid, frame_len, a1);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [4] = '{32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      step();
    end
    idle();
    out_ready = 1'b1;
    total++;
    if ({sel, z} !== {2'd0, w[0]}) begin
      bad++; $display("FAIL bp_beat0: got sel=%0d z=%h want 0 %h", sel, z, w[0]);
    end
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({out_valid, out_last, sel, z, a0, a1, a2, a3} !==
          {1'b1, 1'b0, 2'd1, w[1], w[0], w[1], w[2], w[3]}) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got vld=%b last=%b sel=%0d z=%h bank=%h %h %h %h",
                 c, out_valid, out_last, sel, z, a0, a1, a2, a3);
      end
      step();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      total++;
      if ({out_valid, out_last, sel, z} !== {1'b1, (i == 3), 2'(i), w[i]}) begin
        bad++;
        $display("FAIL bp_resume[%0d]: got vld=%b last=%b sel=%0d z=%h want z=%h",
                 i, out_valid, out_last, sel, z, w[i]);
      end
      step();
    end
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL bp_return: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_drain_ignores_input();
    logic [31:0] w [4] = '{32'hC0000000, 32'hC0000001, 32'hC0000002, 32'hC0000003};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      step();
    end
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({in_ready, out_valid, a0, a3, z} !== {1'b0, 1'b1, w[0], w[3], w[i]}) begin
        bad++;
        $display("FAIL ign_drain[%0d]: got rdy=%b vld=%b a0=%h a3=%h z=%h want z=%h",
                 i, in_ready, out_valid, a0, a3, z, w[i]);
      end
      step();
    end
    out_ready = 1'b0;
    in_data = 32'h0BADF00D; in_last = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL ign_ready_back: got %b want 1", in_ready);
    end
    step();
    idle();
    total++;
    if ({a0, a1, frame_len, out_valid, out_last} !== {32'h0BADF00D, 32'd0, 3'd1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL ign_next_frame: got a0=%h a1=%h len=%0d vld=%b last=%b, want 0badf00d 0 1 1 1",
               a0, a1, frame_len, out_valid, out_last);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] w [4] = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
    in_valid = 1'b1; in_data = 32'h77; step();
    in_data = 32'h88; step();
    idle();
    reset = 1'b1; step(); reset = 1'b0;
    total++;
    if ({in_ready, out_valid, sel, frame_len, a0, a1, a2, a3} !==
        {1'b1, 1'b0, 2'd0, 3'd0, 128'd0}) begin
      bad++;
      $display("FAIL rst_load: got rdy=%b vld=%b sel=%0d len=%0d bank=%h %h %h %h",
               in_ready, out_valid, sel, frame_len, a0, a1, a2, a3);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      step();
    end
    idle();
    total++;
    if ({frame_len, a0, a1, a2, a3} !== {3'd4, w[0], w[1], w[2], w[3]}) begin
      bad++;
      $display("FAIL rst_reload: got len=%0d bank=%h %h %h %h", frame_len, a0, a1, a2, a3);
    end
    out_ready = 1'b1;
    step(); step();
    out_ready = 1'b0;
    total++;
    if ({out_valid, sel, z} !== {1'b1, 2'd2, w[2]}) begin
      bad++; $display("FAIL rst_pre_drain: got vld=%b sel=%0d z=%h", out_valid, sel, z);
    end
    reset = 1'b1; step(); reset = 1'b0;
    total++;
    if ({in_ready, out_valid, out_last, sel, frame_len, a0, a1, a2, a3} !==
        {1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 128'd0}) begin
      bad++;
      $display("FAIL rst_drain: got rdy=%b vld=%b last=%b sel=%0d len=%0d bank=%h %h %h %h",
               in_ready, out_valid, out_last, sel, frame_len, a0, a1, a2, a3);
    end
  endtask

  task automatic test_random();
    logic [32:0] q [$];
    logic [32:0] exp;
    int frames_sent = 0;
    int frames_done = 0;
    int cnt = 0;
    int len = $urandom_range(1, 4);
    int cycles = 0;
    int beat_bad = 0;
    while (frames_done < 200 && cycles < 20000) begin
      in_valid  = (frames_sent < 200) && ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      in_last   = (cnt == len - 1);
      out_ready = ($urandom_range(0, 9) < 7);
      if (in_valid && in_ready) begin
        q.push_back({(cnt == len - 1), in_data});
        cnt++;
        if (cnt == len) begin
          frames_sent++;
          cnt = 0;
          len = $urandom_range(1, 4);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; beat_bad++;
          if (beat_bad < 10) $display("FAIL rand_beat: unexpected z=%h last=%b", z, out_last);
        end else begin
          exp = q.pop_front();
          if ({out_last, z} !== exp) begin
            bad++; beat_bad++;
            if (beat_bad < 10)
              $display("FAIL rand_beat: got last=%b z=%h want last=%b z=%h", out_last, z, exp[32], exp[31:0]);
          end
        end
        if (out_last) frames_done++;
      end
      step();
      cycles++;
    end
    idle();
    total++;
    if (cycles >= 20000) begin
      bad++; $display("FAIL rand_timeout: %0d cycles, frames_done=%0d want 200", cycles, frames_done);
    end
    total++;
    if (frames_done != 200 || q.size() != 0) begin
      bad++;
      $display("FAIL rand_count: got frames=%0d pending=%0d want 200 0", frames_done, q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_drain_ignores_input();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
